// File: rtl/mandelbrot_pkg.sv
// ============================================================================
//  Module   : mandelbrot_pkg
//  Purpose  : Shared widths, screen geometry, the FIFO entry layout and the
//             pixel reader state encoding used by the Mandelbrot datapath.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mandelbrot_pkg;

  localparam int X_WIDTH       = 11;
  localparam int DEPTH_WIDTH   = 9;
  localparam int DATA_WIDTH    = X_WIDTH + DEPTH_WIDTH;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

  // One engine FIFO entry: x in the upper bits, iteration depth in the lower.
  typedef struct packed {
    logic [X_WIDTH-1:0]     x;
    logic [DEPTH_WIDTH-1:0] depth;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } reader_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_pixel_reader.sv
// ============================================================================
//  Module   : fifo_pixel_reader
//  Purpose  : Pops the per-engine result FIFOs in raster order (engine
//             x mod NUM_ENGINES) and emits one depth per pixel on a
//             valid/ready stream with end-of-line and start-of-frame markers.
//  Ports    : clk, reset_n (async, active-low), start (frame kick),
//             fifo_data/fifo_empty/fifo_read_en (show-ahead FIFO bank),
//             out_data/out_valid/out_ready/out_last/out_user (pixel stream),
//             busy, frame_done (pulse), seq_error (sticky x mismatch).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_pixel_reader #(
  parameter int NUM_ENGINES   = 4,
  parameter int X_WIDTH       = mandelbrot_pkg::X_WIDTH,
  parameter int DEPTH_WIDTH   = mandelbrot_pkg::DEPTH_WIDTH,
  parameter int DATA_WIDTH    = X_WIDTH + DEPTH_WIDTH,
  parameter int SCREEN_WIDTH  = mandelbrot_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = mandelbrot_pkg::SCREEN_HEIGHT
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [NUM_ENGINES*DATA_WIDTH-1:0] fifo_data,
  input  logic [NUM_ENGINES-1:0]            fifo_empty,
  output logic [NUM_ENGINES-1:0]            fifo_read_en,
  output logic [DEPTH_WIDTH-1:0]            out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              out_user,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              seq_error
);
  import mandelbrot_pkg::*;

  localparam int ENG_W = (NUM_ENGINES > 1)   ? $clog2(NUM_ENGINES)   : 1;
  localparam int Y_W   = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;

  localparam logic [X_WIDTH-1:0] X_LAST   = X_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [Y_W-1:0]     Y_LAST   = Y_W'(SCREEN_HEIGHT - 1);
  localparam logic [ENG_W-1:0]   ENG_LAST = ENG_W'(NUM_ENGINES - 1);

  reader_state_e           state_q, state_d;
  logic [X_WIDTH-1:0]      x_cnt_q, x_cnt_d;
  logic [Y_W-1:0]          y_cnt_q, y_cnt_d;
  logic [ENG_W-1:0]        eng_sel_q, eng_sel_d;
  logic [DEPTH_WIDTH-1:0]  data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    user_q, user_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   sel_entry;
  logic                    sel_empty;
  logic [X_WIDTH-1:0]      sel_x;
  logic [DEPTH_WIDTH-1:0]  sel_depth;
  logic                    load;

  // Mux out the currently selected engine's head entry and empty flag.
  always_comb begin
    sel_entry = '0;
    sel_empty = 1'b1;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      if (eng_sel_q == ENG_W'(e)) begin
        sel_entry = fifo_data[e*DATA_WIDTH +: DATA_WIDTH];
        sel_empty = fifo_empty[e];
      end
    end
  end

  assign sel_x     = sel_entry[DATA_WIDTH-1:DEPTH_WIDTH];
  assign sel_depth = sel_entry[DEPTH_WIDTH-1:0];

  // A pop happens only when the output register is free or draining this cycle.
  assign load = (state_q == RUN) && !sel_empty && (!valid_q || out_ready);

  always_comb begin
    fifo_read_en = '0;
    for (int e = 0; e < NUM_ENGINES; e++) begin
      fifo_read_en[e] = load && (eng_sel_q == ENG_W'(e));
    end
  end

  always_comb begin
    state_d   = state_q;
    x_cnt_d   = x_cnt_q;
    y_cnt_d   = y_cnt_q;
    eng_sel_d = eng_sel_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    user_d    = user_q;
    err_d     = err_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          x_cnt_d   = '0;
          y_cnt_d   = '0;
          eng_sel_d = '0;
          err_d     = 1'b0;
        end
      end

      RUN: begin
        if (load) begin
          data_d  = sel_depth;
          valid_d = 1'b1;
          last_d  = (x_cnt_q == X_LAST);
          user_d  = (x_cnt_q == '0) && (y_cnt_q == '0);
          if (sel_x != x_cnt_q) begin
            err_d = 1'b1;
          end
          if (x_cnt_q == X_LAST) begin
            // Every line restarts at engine 0 regardless of where the
            // round-robin stopped.
            x_cnt_d   = '0;
            eng_sel_d = '0;
            if (y_cnt_q == Y_LAST) begin
              y_cnt_d = '0;
              state_d = FLUSH;
            end else begin
              y_cnt_d = y_cnt_q + 1'b1;
            end
          end else begin
            x_cnt_d   = x_cnt_q + 1'b1;
            eng_sel_d = (eng_sel_q == ENG_LAST) ? '0 : eng_sel_q + 1'b1;
          end
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          user_d  = 1'b0;
        end
      end

      FLUSH: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          user_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      eng_sel_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      user_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      eng_sel_q <= eng_sel_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      user_q    <= user_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign out_user   = user_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;
  assign seq_error  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_pixel_reader.sv
// ============================================================================
//  Module   : tb_fifo_pixel_reader
//  Purpose  : Directed self-checking bench for fifo_pixel_reader on an 8x2
//             screen with 4 engines, plus a 3-engine instance for the
//             round-robin order with a non-power-of-two engine count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_pixel_reader;

  localparam int NE = 4;
  localparam int SW = 8;
  localparam int SH = 2;
  localparam int NB = SW * SH;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [79:0] fifo_data;
  logic [3:0]  fifo_empty;
  logic [3:0]  fifo_read_en;
  logic [8:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_user;
  logic        busy;
  logic        frame_done;
  logic        seq_error;

  logic        start3;
  logic [59:0] fifo_data3;
  logic [2:0]  fifo_empty3;
  logic [2:0]  fifo_read_en3;
  logic [8:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic        out_last3;
  logic        out_user3;
  logic        busy3;
  logic        frame_done3;
  logic        seq_error3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_pixel_reader #(
    .NUM_ENGINES(NE), .X_WIDTH(11), .DEPTH_WIDTH(9), .DATA_WIDTH(20),
    .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_user(out_user), .busy(busy),
    .frame_done(frame_done), .seq_error(seq_error)
  );

  fifo_pixel_reader #(
    .NUM_ENGINES(3), .X_WIDTH(11), .DEPTH_WIDTH(9), .DATA_WIDTH(20),
    .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
  ) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3),
    .fifo_data(fifo_data3), .fifo_empty(fifo_empty3), .fifo_read_en(fifo_read_en3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_last(out_last3), .out_user(out_user3), .busy(busy3),
    .frame_done(frame_done3), .seq_error(seq_error3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- FIFO bank models (show-ahead) ----------------
  logic [19:0] mem  [4][32];
  int          wr_p [4];
  int          rd_p [4];
  logic        blk2;

  logic [19:0] mem3 [3][32];
  int          wr3  [3];
  int          rd3  [3];

  function automatic logic [19:0] mk(input int x, input int d);
    logic [10:0] xf;
    logic [8:0]  df;
    xf = 11'(x);
    df = 9'(d);
    return {xf, df};
  endfunction

  task automatic refresh();
    for (int e = 0; e < 4; e++) begin
      fifo_empty[e]         = (rd_p[e] == wr_p[e]) || (blk2 && e == 2);
      fifo_data[e*20 +: 20] = mem[e][rd_p[e] % 32];
    end
  endtask

  task automatic refresh3();
    for (int e = 0; e < 3; e++) begin
      fifo_empty3[e]         = (rd3[e] == wr3[e]);
      fifo_data3[e*20 +: 20] = mem3[e][rd3[e] % 32];
    end
  endtask

  // Load a full frame: pixel x goes to engine x%4 with depth x+10.
  // With corrupt set, the entry for pixel (1,0) carries x=5.
  task automatic preload(input bit corrupt);
    for (int e = 0; e < 4; e++) begin
      wr_p[e] = 0;
      rd_p[e] = 0;
    end
    for (int k = 0; k < NB; k++) begin
      int x;
      int e;
      int xf;
      x  = k % SW;
      e  = x % NE;
      xf = (corrupt && k == 1) ? 5 : x;
      mem[e][wr_p[e]] = mk(xf, x + 10);
      wr_p[e]++;
    end
  endtask

  // Runs one frame on u_dut. Called #1 after a rising edge.
  //   ready_mode 0: out_ready always 1; 1: pattern 1,0,0,1 repeating
  //   blk        >0: engine 2 reads as empty until that cycle
  //   rst_beat   >=0: assert reset once that many beats have handshaken
  task automatic run_frame(input int ready_mode, input int blk, input int rst_beat, input bit corrupt);
    int   beats;
    int   pops;
    int   last_hs;
    int   rd_e;
    bit   done;
    bit   p_stall;
    logic [8:0] p_data;
    logic p_last;
    logic p_user;
    logic [3:0] rd;

    preload(corrupt);
    blk2      = (blk > 0);
    out_ready = 1'b1;
    refresh();
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    out_ready = 1'b1;

    beats   = 0;
    pops    = 0;
    last_hs = -100;
    done    = 1'b0;
    p_stall = 1'b0;
    p_data  = '0;
    p_last  = 1'b0;
    p_user  = 1'b0;

    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      rd   = fifo_read_en;
      rd_e = -1;

      if (cyc == 0) check_val("err_cleared_on_start", seq_error, 0);
      if (corrupt && cyc == 1) check_val("err_before_bad", seq_error, 0);
      if (corrupt && cyc == 2) check_val("err_after_bad", seq_error, 1);

      if (p_stall) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_data", out_data, p_data);
        check_val("hold_last", out_last, p_last);
        check_val("hold_user", out_user, p_user);
      end

      if (rd != 4'b0) begin
        check_val("pop_onehot", $onehot(rd), 1);
        for (int e = 0; e < 4; e++) if (rd[e]) rd_e = e;
        check_val("pop_engine", rd_e, (pops % SW) % NE);
        check_val("pop_nonempty", fifo_empty[rd_e], 0);
        pops++;
      end
      if (out_valid && !out_ready) check_val("pop_while_stall", rd, 0);
      if (blk > 0 && cyc >= 2 && cyc < blk) check_val("empty_no_pop", rd, 0);
      if (blk > 0 && cyc == 5) check_val("empty_valid_drop", out_valid, 0);

      if (out_valid && out_ready) begin
        check_val("beat_data", out_data, (beats % SW) + 10);
        check_val("beat_last", out_last, ((beats % SW) == SW - 1) ? 1 : 0);
        check_val("beat_user", out_user, (beats == 0) ? 1 : 0);
        if (ready_mode == 0 && blk == 0) check_val("beat_cycle", cyc, beats + 1);
        if (blk > 0 && beats == 2) check_val("resume_cycle", cyc, blk + 1);
        if (beats == NB - 1) last_hs = cyc;
        beats++;
      end

      if (frame_done) begin
        check_val("done_cycle", cyc, last_hs + 1);
        check_val("done_busy", busy, 0);
        check_val("done_beats", beats, NB);
        check_val("done_pops", pops, NB);
        check_val("done_seq_error", seq_error, corrupt ? 1 : 0);
        done = 1'b1;
      end else if (rst_beat >= 0 && beats == rst_beat) begin
        reset_n = 1'b0;
        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_last", out_last, 0);
        check_val("rst_user", out_user, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_read_en", fifo_read_en, 0);
        check_val("rst_done", frame_done, 0);
        done = 1'b1;
      end

      p_stall = out_valid && !out_ready;
      p_data  = out_data;
      p_last  = out_last;
      p_user  = out_user;

      @(posedge clk);
      #1;
      if (rd_e >= 0) rd_p[rd_e]++;
      if (ready_mode != 0) out_ready = (((cyc + 1) % 4) == 0) || (((cyc + 1) % 4) == 3);
      blk2 = (blk > 0) && (cyc + 1 < blk);
      refresh();
    end
    if (!done) check_val("frame_timeout", 0, 1);
    out_ready = 1'b1;
    blk2      = 1'b0;
    refresh();
  endtask

  // Engine order for the 3-engine instance across a full frame.
  task automatic run_three();
    int  pops;
    int  rd_e;
    bit  done;
    for (int e = 0; e < 3; e++) begin
      wr3[e] = 0;
      rd3[e] = 0;
    end
    for (int k = 0; k < NB; k++) begin
      int x;
      int e;
      x = k % SW;
      e = x % 3;
      mem3[e][wr3[e]] = mk(x, x + 10);
      wr3[e]++;
    end
    refresh3();
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    pops   = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      rd_e = -1;
      if (fifo_read_en3 != 3'b0) begin
        check_val("e3_onehot", $onehot(fifo_read_en3), 1);
        for (int e = 0; e < 3; e++) if (fifo_read_en3[e]) rd_e = e;
        check_val("e3_engine", rd_e, (pops % SW) % 3);
        pops++;
      end
      if (frame_done3) done = 1'b1;
      @(posedge clk);
      #1;
      if (rd_e >= 0) rd3[rd_e]++;
      refresh3();
    end
    check_val("e3_done", done, 1);
    check_val("e3_pops", pops, NB);
    check_val("e3_seq_error", seq_error3, 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    start3     = 1'b0;
    out_ready  = 1'b1;
    out_ready3 = 1'b1;
    blk2       = 1'b0;
    fifo_data  = '0;
    fifo_data3 = '0;
    for (int e = 0; e < 4; e++) begin
      wr_p[e] = 0;
      rd_p[e] = 0;
      for (int a = 0; a < 32; a++) mem[e][a] = '0;
    end
    for (int e = 0; e < 3; e++) begin
      wr3[e] = 0;
      rd3[e] = 0;
      for (int a = 0; a < 32; a++) mem3[e][a] = '0;
    end
    refresh();
    refresh3();

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_val("reset_valid", out_valid, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_read_en", fifo_read_en, 0);
    check_val("reset_done", frame_done, 0);
    check_val("reset_seq_error", seq_error, 0);
    @(posedge clk);
    #1;

    run_frame(0, 0, -1, 1'b0);   // nominal frame
    run_frame(0, 20, -1, 1'b0);  // engine 2 starved until cycle 20
    run_frame(1, 0, -1, 1'b0);   // back-pressure 1,0,0,1
    run_frame(0, 0, -1, 1'b1);   // bad x from engine 1
    run_frame(0, 0, 6, 1'b0);    // reset mid-frame at beat 6
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(0, 0, -1, 1'b0);   // clean restart after reset
    run_three();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
